// File: rtl/udma_pkg.sv
// Shared constants for the uDMA peripheral configuration responder:
// default widths, register word indices and CFG register bit positions.
package udma_pkg;

  localparam int unsigned L2_AWIDTH_NOAL = 19;
  localparam int unsigned TRANS_SIZE     = 20;

  // Register word indices on the configuration bus
  localparam logic [4:0] REG_RX_SADDR = 5'd0;
  localparam logic [4:0] REG_RX_SIZE  = 5'd1;
  localparam logic [4:0] REG_RX_CFG   = 5'd2;
  localparam logic [4:0] REG_TX_SADDR = 5'd4;
  localparam logic [4:0] REG_TX_SIZE  = 5'd5;
  localparam logic [4:0] REG_TX_CFG   = 5'd6;
  localparam logic [4:0] REG_SETUP    = 5'd9;

  // Offsets of the three registers inside one channel block
  localparam logic [1:0] CH_SADDR = 2'd0;
  localparam logic [1:0] CH_SIZE  = 2'd1;
  localparam logic [1:0] CH_CFG   = 2'd2;

  // CFG register bit positions
  localparam int unsigned CFG_CONT_BIT = 0;
  localparam int unsigned CFG_DS_LSB   = 1;
  localparam int unsigned CFG_DS_MSB   = 2;
  localparam int unsigned CFG_EN_BIT   = 4;
  localparam int unsigned CFG_PEND_BIT = 5;
  localparam int unsigned CFG_CLR_BIT  = 6;

  // True when addr falls inside the three-register block starting at base
  function automatic logic in_channel(input logic [4:0] addr, input logic [4:0] base);
    return (addr >= base) && (addr <= (base + 5'd2));
  endfunction

  // Offset of addr within the channel block starting at base
  function automatic logic [1:0] ch_offset(input logic [4:0] addr, input logic [4:0] base);
    logic [4:0] diff;
    diff = addr - base;
    return diff[1:0];
  endfunction

endpackage

// File: rtl/udma_cfg_ch_regs.sv
// One uDMA channel register set (SADDR / SIZE / CFG): holds the programmed
// values, produces the one-cycle start/clear pulses and builds the readback
// word from live channel status.
// Build option: UDMA_CFG_CLR_EN enables the CFG bit6 clear pulse.
module udma_cfg_ch_regs
  import udma_pkg::*;
#(
  parameter int unsigned AW = 19,
  parameter int unsigned TW = 20
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [1:0]    idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o,
  input  logic [AW-1:0] curr_addr_i,
  input  logic [TW-1:0] bytes_left_i,
  input  logic          busy_i,
  input  logic          pending_i,
  output logic [AW-1:0] startaddr_o,
  output logic [TW-1:0] size_o,
  output logic [1:0]    datasize_o,
  output logic          continuous_o,
  output logic          en_o,
  output logic          clr_o
);

  logic [AW-1:0] saddr_q, saddr_d;
  logic [TW-1:0] size_q, size_d;
  logic [1:0]    ds_q, ds_d;
  logic          cont_q, cont_d;
  logic          en_q, en_d;
`ifdef UDMA_CFG_CLR_EN
  logic          clr_q, clr_d;
`endif
  logic [31:0]   cfg_rd_s;
  logic          unused_wdata_s;

  // Write data bits beyond the field widths are intentionally dropped
  assign unused_wdata_s = ^wdata_i;

  // Next-state of the channel registers; pulses default low every cycle
  always_comb begin
    saddr_d = saddr_q;
    size_d  = size_q;
    ds_d    = ds_q;
    cont_d  = cont_q;
    en_d    = 1'b0;
`ifdef UDMA_CFG_CLR_EN
    clr_d   = 1'b0;
`endif
    if (we_i) begin
      case (idx_i)
        CH_SADDR: saddr_d = wdata_i[AW-1:0];
        CH_SIZE:  size_d  = wdata_i[TW-1:0];
        CH_CFG: begin
          cont_d = wdata_i[CFG_CONT_BIT];
          ds_d   = wdata_i[CFG_DS_MSB:CFG_DS_LSB];
`ifdef UDMA_CFG_CLR_EN
          // A clear in the same write suppresses the start
          clr_d  = wdata_i[CFG_CLR_BIT];
          en_d   = wdata_i[CFG_EN_BIT] & ~wdata_i[CFG_CLR_BIT];
`else
          en_d   = wdata_i[CFG_EN_BIT];
`endif
        end
        default: saddr_d = saddr_q;
      endcase
    end else begin
      saddr_d = saddr_q;
    end
  end

  // Channel register state with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      saddr_q <= '0;
      size_q  <= '0;
      ds_q    <= 2'd0;
      cont_q  <= 1'b0;
      en_q    <= 1'b0;
`ifdef UDMA_CFG_CLR_EN
      clr_q   <= 1'b0;
`endif
    end else begin
      saddr_q <= saddr_d;
      size_q  <= size_d;
      ds_q    <= ds_d;
      cont_q  <= cont_d;
      en_q    <= en_d;
`ifdef UDMA_CFG_CLR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Readback word: live status for SADDR/SIZE, programmed fields plus status for CFG
  always_comb begin
    cfg_rd_s                          = 32'h0;
    cfg_rd_s[CFG_CONT_BIT]            = cont_q;
    cfg_rd_s[CFG_DS_MSB:CFG_DS_LSB]   = ds_q;
    cfg_rd_s[CFG_EN_BIT]              = busy_i;
    cfg_rd_s[CFG_PEND_BIT]            = pending_i;
    case (idx_i)
      CH_SADDR: rdata_o = 32'(curr_addr_i);
      CH_SIZE:  rdata_o = 32'(bytes_left_i);
      CH_CFG:   rdata_o = cfg_rd_s;
      default:  rdata_o = 32'h0;
    endcase
  end

  assign startaddr_o  = saddr_q;
  assign size_o       = size_q;
  assign datasize_o   = ds_q;
  assign continuous_o = cont_q;
  assign en_o         = en_q;
`ifdef UDMA_CFG_CLR_EN
  assign clr_o        = clr_q;
`else
  assign clr_o        = 1'b0;
`endif

endmodule

// File: rtl/udma_periph_cfg_if.sv
// uDMA peripheral configuration bus responder. Two-state handshake (IDLE ->
// RESP -> IDLE): writes commit and reads are captured on the IDLE edge, ready
// is high for the single RESP cycle. Holds the RX/TX channel registers and
// the peripheral SETUP register.
// Build option: UDMA_CFG_CLR_EN enables the CFG bit6 clear pulse.
module udma_periph_cfg_if #(
  parameter int unsigned L2_AWIDTH_NOAL = udma_pkg::L2_AWIDTH_NOAL,
  parameter int unsigned TRANS_SIZE     = udma_pkg::TRANS_SIZE,
  parameter logic [31:0] SETUP_RST      = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               cfg_data_i,
  input  logic [4:0]                cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_rwn_i,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_ready_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic [1:0]                cfg_rx_datasize_o,
  output logic                      cfg_rx_continuous_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
  input  logic                      cfg_rx_busy_i,
  input  logic                      cfg_rx_pending_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
  output logic [1:0]                cfg_tx_datasize_o,
  output logic                      cfg_tx_continuous_o,
  output logic                      cfg_tx_en_o,
  output logic                      cfg_tx_clr_o,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,
  input  logic                      cfg_tx_busy_i,
  input  logic                      cfg_tx_pending_i,
  output logic [31:0]               setup_o
);

  import udma_pkg::*;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] data_q, data_d;
  logic [31:0] setup_q, setup_d;
  logic        rx_we_s, tx_we_s;
  logic [31:0] rx_rdata_s, tx_rdata_s, rd_mux_s;

  // Read data selection by word index; unmapped indices read as zero
  always_comb begin
    case (cfg_addr_i)
      REG_RX_SADDR, REG_RX_SIZE, REG_RX_CFG: rd_mux_s = rx_rdata_s;
      REG_TX_SADDR, REG_TX_SIZE, REG_TX_CFG: rd_mux_s = tx_rdata_s;
      REG_SETUP:                             rd_mux_s = setup_q;
      default:                               rd_mux_s = 32'h0;
    endcase
  end

  // Handshake FSM: accept in IDLE, answer for exactly one RESP cycle
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    data_d  = data_q;
    setup_d = setup_q;
    rx_we_s = 1'b0;
    tx_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          if (cfg_rwn_i) begin
            data_d = rd_mux_s;
          end else begin
            rx_we_s = in_channel(cfg_addr_i, REG_RX_SADDR);
            tx_we_s = in_channel(cfg_addr_i, REG_TX_SADDR);
            if (cfg_addr_i == REG_SETUP) begin
              setup_d = cfg_data_i;
            end else begin
              setup_d = setup_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      // valid is deliberately ignored here so an access cannot commit twice
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and SETUP state with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      data_q  <= 32'h0;
      setup_q <= SETUP_RST;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      setup_q <= setup_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign cfg_data_o  = data_q;
  assign setup_o     = setup_q;

  udma_cfg_ch_regs #(
    .AW (L2_AWIDTH_NOAL),
    .TW (TRANS_SIZE)
  ) u_rx_regs (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .we_i         (rx_we_s),
    .idx_i        (ch_offset(cfg_addr_i, REG_RX_SADDR)),
    .wdata_i      (cfg_data_i),
    .rdata_o      (rx_rdata_s),
    .curr_addr_i  (cfg_rx_curr_addr_i),
    .bytes_left_i (cfg_rx_bytes_left_i),
    .busy_i       (cfg_rx_busy_i),
    .pending_i    (cfg_rx_pending_i),
    .startaddr_o  (cfg_rx_startaddr_o),
    .size_o       (cfg_rx_size_o),
    .datasize_o   (cfg_rx_datasize_o),
    .continuous_o (cfg_rx_continuous_o),
    .en_o         (cfg_rx_en_o),
    .clr_o        (cfg_rx_clr_o)
  );

  udma_cfg_ch_regs #(
    .AW (L2_AWIDTH_NOAL),
    .TW (TRANS_SIZE)
  ) u_tx_regs (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .we_i         (tx_we_s),
    .idx_i        (ch_offset(cfg_addr_i, REG_TX_SADDR)),
    .wdata_i      (cfg_data_i),
    .rdata_o      (tx_rdata_s),
    .curr_addr_i  (cfg_tx_curr_addr_i),
    .bytes_left_i (cfg_tx_bytes_left_i),
    .busy_i       (cfg_tx_busy_i),
    .pending_i    (cfg_tx_pending_i),
    .startaddr_o  (cfg_tx_startaddr_o),
    .size_o       (cfg_tx_size_o),
    .datasize_o   (cfg_tx_datasize_o),
    .continuous_o (cfg_tx_continuous_o),
    .en_o         (cfg_tx_en_o),
    .clr_o        (cfg_tx_clr_o)
  );

endmodule

// File: doc/udma_periph_cfg_if.md
# udma_periph_cfg_if

Responder for the uDMA peripheral configuration bus (data_to/addr/rwn/valid/ready/data_from) driven by the core's APB bridge. One instance sits inside each uDMA peripheral. It holds the RX and TX channel register set: start address, size, datasize, continuous, enable and clear. It emits one-cycle start and clear pulses to the channel logic and reads back live channel status. A peripheral-specific SETUP register is provided for the host protocol block.

## Interface
- L2_AWIDTH_NOAL, default udma_pkg::L2_AWIDTH_NOAL: channel address width.
- TRANS_SIZE, default udma_pkg::TRANS_SIZE: size/bytes-left width.
- SETUP_RST, default 32'h0: reset value of SETUP.
- clk_i, input, 1: sole clock (peripheral sys clock).
- rst_i, input, 1: asynchronous, active-high reset.
- cfg_data_i, input, 32: write data.
- cfg_addr_i, input, 5: word index.
- cfg_valid_i, input, 1: access request.
- cfg_rwn_i, input, 1: 1 = read, 0 = write.
- cfg_data_o, output, 32: read data.
- cfg_ready_o, output, 1: access complete.
- cfg_rx_startaddr_o / cfg_tx_startaddr_o, output, L2_AWIDTH_NOAL: channel start address.
- cfg_rx_size_o / cfg_tx_size_o, output, TRANS_SIZE: transfer size in bytes.
- cfg_rx_datasize_o / cfg_tx_datasize_o, output, 2: 0 = byte, 1 = half, 2 = word.
- cfg_rx_continuous_o / cfg_tx_continuous_o, output, 1: auto-reload.
- cfg_rx_en_o / cfg_tx_en_o, output, 1: start pulse.
- cfg_rx_clr_o / cfg_tx_clr_o, output, 1: clear pulse.
- cfg_rx_curr_addr_i / cfg_tx_curr_addr_i, input, L2_AWIDTH_NOAL: live address.
- cfg_rx_bytes_left_i / cfg_tx_bytes_left_i, input, TRANS_SIZE: live remaining bytes.
- cfg_rx_busy_i / cfg_tx_busy_i, input, 1: channel active.
- cfg_rx_pending_i / cfg_tx_pending_i, input, 1: a second transfer is queued.
- setup_o, output, 32: SETUP register.

## Operation
- Register map, by word index:
  - 0: RX_SADDR. Write sets the start address; read returns cfg_rx_curr_addr_i.
  - 1: RX_SIZE. Write sets the size; read returns cfg_rx_bytes_left_i.
  - 2: RX_CFG.
    - bit0: continuous.
    - bits[2:1]: datasize.
    - bit4: en. Writing 1 starts the channel; reads return busy.
    - bit5: pending (read only).
    - bit6: clr.
  - 4, 5, 6: TX_SADDR, TX_SIZE, TX_CFG, same layout as RX.
  - 9: SETUP, read/write.
  - All other indices: reads return 0, writes are ignored.
- Partial-width fields: write data is truncated to field width; read data is zero-extended.
- State machine has two states, IDLE and RESP.
  - In IDLE with cfg_valid_i=1: a write commits at this edge; a read samples its data into cfg_data_o; go to RESP.
  - RESP lasts exactly one cycle with cfg_ready_o=1, then returns to IDLE unconditionally.
  - cfg_valid_i is ignored while in RESP, so an access can never commit twice.
- A CFG write with en=1 produces a one-cycle pulse on cfg_*_en_o in the RESP cycle.
  - The pulse is emitted regardless of busy; queuing is the channel's responsibility.
  - The continuous and datasize fields update on the same edge as the write.
- A CFG write with clr=1 produces a one-cycle pulse on cfg_*_clr_o.
  - If en and clr are both set in one write, clr wins and no en pulse is emitted.
- RX and TX are fully independent.

## Timing
- Write latency: the register output changes at the edge after valid is sampled in IDLE. cfg_ready_o is high in that following cycle.
- Read latency: cfg_data_o is valid in the ready cycle. It holds its last value at all other times; it is not zeroed.
- Back-to-back throughput: one access every 2 cycles.
- Reset values of every output:
  - cfg_ready_o=0, cfg_data_o=0.
  - All startaddr, size, datasize, continuous, en and clr outputs = 0.
  - setup_o=SETUP_RST.
  - State = IDLE.
- Reset asserted mid-access: the access is dropped, no pulse is emitted, and ready is not asserted.
- Status read: the inputs are sampled on the IDLE edge, so the returned data reflects that cycle.

## Configuration
- UDMA_CFG_CLR_EN defined:
  - CFG bit6 generates the clr pulse.
  - The clr-wins rule applies.
- UDMA_CFG_CLR_EN undefined:
  - bit6 is ignored.
  - cfg_*_clr_o are tied to 0.
  - CFG reads return 0 in bit6 in both builds.

## Structure
- Register index constants go in udma_pkg: REG_RX_SADDR=0, REG_RX_SIZE=1, REG_RX_CFG=2, REG_TX_SADDR=4, REG_TX_SIZE=5, REG_TX_CFG=6, REG_SETUP=9.
- CFG bit-position constants also go in udma_pkg.
- The FSM state enum stays local.
- One natural sub-module, udma_cfg_ch_regs:
  - Holds one channel's SADDR/SIZE/CFG registers and generates its pulses.
  - Instantiated twice, once for RX and once for TX.

## Test plan
- Reset: all outputs at their reset values; read of index 2 with busy=0 returns 0x0.
- Write 0x1C000100 to index 0, then 256 to index 1, then 0x15 to index 2:
  - startaddr = 0x1C000100 truncated to L2_AWIDTH_NOAL.
  - size = 256, continuous = 1, datasize = 2.
  - One cfg_rx_en_o pulse in the ready cycle.
- Read index 5 with cfg_tx_bytes_left_i=40: data 40 in the ready cycle; ready is high for exactly 1 cycle.
- Hold cfg_valid_i high for 4 cycles on a write of 0x10 to index 6:
  - ready pulses at cycles 2 and 4.
  - Two tx_en pulses, with no commit in either RESP cycle.
- With UDMA_CFG_CLR_EN, write 0x50 to index 2: one clr pulse, no en pulse. Without the macro: one en pulse only.
- Assert rst_i in the cycle after a write to index 9 is sampled: setup_o returns to SETUP_RST and no ready is seen.
